pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central interlock controller for the five-stage SimpleRISC pipeline (IF, OF, EX, DM, WB). The forwarding network cannot cover three cases, and this block handles them by sequencing pipeline-register enables, bubbles and flushes:
- load-use hazards (loaded value not available until after DM);
- multi-cycle EX operations (mul/div);
- taken branches resolved in EX.

It also counts stall cycles and flags a hung multi-cycle unit.

## Interface
Parameters:
- MC_MAX_CYCLES, default 32: maximum cycles spent in MC_WAIT before a timeout is declared (range 2..255).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1_OF, rs2_OF  input  5 each  source register numbers of the instruction in OF.
- rs1_used_OF, rs2_used_OF  input  1 each  the OF instruction actually reads that source.
- rd_EX  input  5  destination register of the instruction in EX.
- is_ld_EX  input  1  the EX instruction is a load.
- mc_start_EX  input  1  the EX instruction is multi-cycle. High for its first EX cycle only.
- mc_done  input  1  the multi-cycle unit's result is valid this cycle.
- branch_taken_EX  input  1  the EX instruction is a taken branch or jump.
- pc_write_en  output  1  PC may update.
- if_of_write_en  output  1  IF/OF register may load.
- if_of_flush  output  1  IF/OF register loads a NOP.
- of_ex_bubble  output  1  OF/EX register loads a NOP.
- ex_hold  output  1  OF/EX register holds its contents.
- dm_bubble  output  1  EX/DM register loads a NOP.
- stall_cycles  output  16  saturating count of cycles with pc_write_en=0.
- mc_timeout  output  1  sticky error flag.

## Operation
- FSM states: RUN, LD_STALL, MC_WAIT, ERROR.
- Default outputs, used in RUN with no hazard and in LD_STALL: pc_write_en=1, if_of_write_en=1, all other 1-bit outputs 0.
- Load-use hazard condition: is_ld_EX, rd_EX≠0, and a match on any used source, i.e. (rs1_used_OF and rs1_OF==rd_EX) or (rs2_used_OF and rs2_OF==rd_EX).
- RUN, hazards evaluated in priority order (encoding makes them mutually exclusive; priority is still mandatory):
  1. mc_start_EX=1 and mc_done=0: pc_write_en=0, if_of_write_en=0, ex_hold=1, dm_bubble=1. Next state MC_WAIT, wait counter loaded with 1. If mc_done=1 in the same cycle: default outputs, stay in RUN.
  2. branch_taken_EX=1: if_of_flush=1, of_ex_bubble=1, pc_write_en=1. Stay in RUN.
  3. Load-use hazard: pc_write_en=0, if_of_write_en=0, of_ex_bubble=1. Next state LD_STALL.
- LD_STALL: default outputs, hazard detection suppressed. Next state RUN. Guarantees exactly one stall cycle per load-use.
- MC_WAIT, mc_done=0:
  - Outputs as in RUN item 1; wait counter increments.
  - branch_taken_EX, is_ld_EX and the load-use terms are ignored.
  - If the counter equals MC_MAX_CYCLES, next state ERROR.
- MC_WAIT, mc_done=1: default outputs (release cycle). Next state RUN; counter cleared.
- ERROR: pc_write_en=0, if_of_write_en=0, ex_hold=1, dm_bubble=1, mc_timeout=1. The state is absorbing; only rst_n exits it.
- stall_cycles: increments on every rising edge where pc_write_en=0. Saturates at 0xFFFF, no wrap. Counts ERROR cycles as well.
- Wait counter: 8 bits, internal.

## Timing
- All outputs except stall_cycles and mc_timeout are combinational from the current state and inputs, valid in the same cycle (zero latency). The datapath samples them at the next edge.
- State, wait counter, stall_cycles and mc_timeout are registered.
- Asynchronous reset (rst_n=0) forces state=RUN, wait counter=0, stall_cycles=0, mc_timeout=0. While in reset, outputs follow RUN decoding: pc_write_en=1, if_of_write_en=1, other outputs 0 when inputs are idle.
- Reset mid-MC_WAIT or mid-ERROR returns to RUN immediately, without waiting for a clock edge.
- Load-use costs exactly one bubble. Branch costs two squashed slots, both in the same cycle. A multi-cycle op of N total EX cycles costs N−1 stall cycles.

## Test plan
- Load-use: load r3 in EX, OF reads r3 via rs2 (rs2_used=1) → one cycle with pc_write_en=0 and of_ex_bubble=1, then LD_STALL with default outputs, then RUN; stall_cycles=1. Repeat with rd_EX=0 → no stall.
- Unused source: rs1_OF=r5=rd_EX, is_ld_EX=1, rs1_used_OF=0 → no stall.
- Branch: branch_taken_EX=1 → if_of_flush=1, of_ex_bubble=1, pc_write_en=1 in that cycle only; stall_cycles unchanged.
- Multi-cycle: mc_start_EX pulse with mc_done arriving 4 cycles later → 4 cycles with ex_hold=1 and dm_bubble=1, release on the mc_done cycle; stall_cycles=4. Same-cycle mc_start_EX and mc_done → no stall.
- Timeout: MC_MAX_CYCLES=4, mc_done never asserted → ERROR entered after 4 MC_WAIT cycles; mc_timeout=1 and stays 1. A branch_taken_EX pulse there is ignored. rst_n low mid-ERROR → outputs at reset values, mc_timeout=0 asynchronously.
- Saturation: force a continuous stall for more than 65535 cycles → stall_cycles holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Interlock controller for the five-stage pipeline. It sequences PC and
// pipeline-register enables, bubbles and flushes for three cases:
// load-use hazards, multi-cycle EX operations and taken branches.
// It also counts stall cycles and latches a sticky timeout flag when the
// multi-cycle unit stops responding.
//
// Handshake: mc_start_EX is a one-cycle request from EX. mc_done is the
// unit's completion strobe and is honoured in the cycle it is seen. If
// mc_done arrives together with mc_start_EX, no stall is taken.
//
// The pipeline-control outputs are combinational from the current state
// and inputs. stall_cycles and mc_timeout are registered. fsm_state exposes
// the current FSM state for debug and checker binding.
module pipeline_hazard_controller #(
  parameter int MC_MAX_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_OF,
  input  logic [4:0]  rs2_OF,
  input  logic        rs1_used_OF,
  input  logic        rs2_used_OF,
  input  logic [4:0]  rd_EX,
  input  logic        is_ld_EX,
  input  logic        mc_start_EX,
  input  logic        mc_done,
  input  logic        branch_taken_EX,
  output logic        pc_write_en,
  output logic        if_of_write_en,
  output logic        if_of_flush,
  output logic        of_ex_bubble,
  output logic        ex_hold,
  output logic        dm_bubble,
  output logic [15:0] stall_cycles,
  output logic        mc_timeout,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    ERROR    = 2'd3
  } state_e;

  localparam logic [7:0] MC_LIMIT = 8'(MC_MAX_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mc_timeout_q, mc_timeout_d;
  logic        load_use;

  // A loaded value is needed by OF before it exists; register 0 never hazards.
  assign load_use = is_ld_EX && (rd_EX != 5'd0) &&
                    ((rs1_used_OF && (rs1_OF == rd_EX)) ||
                     (rs2_used_OF && (rs2_OF == rd_EX)));

  // Next-state and combinational pipeline-control decode.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    pc_write_en    = 1'b1;
    if_of_write_en = 1'b1;
    if_of_flush    = 1'b0;
    of_ex_bubble   = 1'b0;
    ex_hold        = 1'b0;
    dm_bubble      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mc_start_EX && !mc_done) begin
          pc_write_en    = 1'b0;
          if_of_write_en = 1'b0;
          ex_hold        = 1'b1;
          dm_bubble      = 1'b1;
          state_d        = MC_WAIT;
          wait_cnt_d     = 8'd1;
        end else if (mc_start_EX) begin
          // Result ready on the first EX cycle: nothing to wait for.
          state_d = RUN;
        end else if (branch_taken_EX) begin
          // Squash the wrong-path instructions in IF/OF and OF.
          if_of_flush  = 1'b1;
          of_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write_en    = 1'b0;
          if_of_write_en = 1'b0;
          of_ex_bubble   = 1'b1;
          state_d        = LD_STALL;
        end
      end
      LD_STALL: begin
        // The load has moved to DM; forwarding covers the consumer now.
        state_d = RUN;
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          pc_write_en    = 1'b0;
          if_of_write_en = 1'b0;
          ex_hold        = 1'b1;
          dm_bubble      = 1'b1;
          wait_cnt_d     = wait_cnt_q + 8'd1;
          if (wait_cnt_q == MC_LIMIT) begin
            state_d    = ERROR;
            wait_cnt_d = 8'd0;
          end
        end
      end
      ERROR: begin
        // Freeze the pipeline until reset.
        pc_write_en    = 1'b0;
        if_of_write_en = 1'b0;
        ex_hold        = 1'b1;
        dm_bubble      = 1'b1;
        state_d        = ERROR;
      end
      default: state_d = RUN;
    endcase
  end

  // Stall counter saturates so a long hang still reads as "very long".
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Timeout flag is sticky; it is set on the edge that enters ERROR.
  always_comb begin
    mc_timeout_d = mc_timeout_q || (state_d == ERROR);
  end

  // State, wait counter, stall counter and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wait_cnt_q   <= 8'd0;
      stall_cnt_q  <= 16'd0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign mc_timeout   = mc_timeout_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller (MC_MAX_CYCLES = 4).
// Pipeline-control outputs are packed as
// {pc_write_en, if_of_write_en, if_of_flush, of_ex_bubble, ex_hold, dm_bubble}.
module tb_pipeline_hazard_controller;

  localparam int MC_MAX = 4;

  localparam logic [5:0] O_DEF = 6'b110000;
  localparam logic [5:0] O_LDU = 6'b000100;
  localparam logic [5:0] O_BR  = 6'b111100;
  localparam logic [5:0] O_MC  = 6'b000011;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LDS = 2'd1;
  localparam logic [1:0] S_MCW = 2'd2;
  localparam logic [1:0] S_ERR = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_OF, rs2_OF, rd_EX;
  logic        rs1_used_OF, rs2_used_OF;
  logic        is_ld_EX, mc_start_EX, mc_done, branch_taken_EX;
  logic        pc_write_en, if_of_write_en, if_of_flush;
  logic        of_ex_bubble, ex_hold, dm_bubble;
  logic [15:0] stall_cycles;
  logic        mc_timeout;
  logic [1:0]  fsm_state;

  logic [5:0] exp_q[$];
  int n_cmp;
  int n_bad;

  pipeline_hazard_controller #(.MC_MAX_CYCLES(MC_MAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_OF          (rs1_OF),
    .rs2_OF          (rs2_OF),
    .rs1_used_OF     (rs1_used_OF),
    .rs2_used_OF     (rs2_used_OF),
    .rd_EX           (rd_EX),
    .is_ld_EX        (is_ld_EX),
    .mc_start_EX     (mc_start_EX),
    .mc_done         (mc_done),
    .branch_taken_EX (branch_taken_EX),
    .pc_write_en     (pc_write_en),
    .if_of_write_en  (if_of_write_en),
    .if_of_flush     (if_of_flush),
    .of_ex_bubble    (of_ex_bubble),
    .ex_hold         (ex_hold),
    .dm_bubble       (dm_bubble),
    .stall_cycles    (stall_cycles),
    .mc_timeout      (mc_timeout),
    .fsm_state       (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, pc_write_en, if_of_write_en, if_of_flush, of_ex_bubble, ex_hold, dm_bubble};
  endfunction

  // Driver tasks
  task automatic drive_idle();
    rs1_OF = 5'd0; rs2_OF = 5'd0; rd_EX = 5'd0;
    rs1_used_OF = 1'b0; rs2_used_OF = 1'b0;
    is_ld_EX = 1'b0; mc_start_EX = 1'b0; mc_done = 1'b0; branch_taken_EX = 1'b0;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
    drive_idle();
    is_ld_EX = 1'b1; rd_EX = rd;
    rs1_OF = r1; rs1_used_OF = u1;
    rs2_OF = r2; rs2_used_OF = u2;
  endtask

  // Advance one clock; leave time 1 unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive_idle();
    rst_n = 1'b0;
    #12;
    check("reset_outs", outs(), {26'd0, O_DEF});
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_timeout", 32'(mc_timeout), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(S_RUN));
    rst_n = 1'b1;
    tick();

    // Load-use through rs2
    drive_ld(5'd3, 5'd7, 1'b1, 5'd3, 1'b1);
    #1 check("ldu_rs2_outs", outs(), {26'd0, O_LDU});
    tick();
    check("ldu_stall_state", 32'(fsm_state), 32'(S_LDS));
    check("ldu_stall_outs", outs(), {26'd0, O_DEF});
    tick();
    drive_idle();
    #1 check("ldu_back_run", 32'(fsm_state), 32'(S_RUN));
    check("ldu_count", 32'(stall_cycles), 32'd1);

    // rd_EX = 0 never hazards
    drive_ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 check("ldu_r0_outs", outs(), {26'd0, O_DEF});
    tick();
    check("ldu_r0_state", 32'(fsm_state), 32'(S_RUN));

    // Matching but unused source
    drive_ld(5'd5, 5'd5, 1'b0, 5'd9, 1'b1);
    #1 check("unused_src_outs", outs(), {26'd0, O_DEF});
    // Same match through a used rs1
    rs1_used_OF = 1'b1;
    #1 check("ldu_rs1_outs", outs(), {26'd0, O_LDU});
    tick();
    drive_idle();
    tick();
    check("ldu_rs1_count", 32'(stall_cycles), 32'd2);

    // Taken branch, also with a load-use present: branch wins
    branch_taken_EX = 1'b1;
    #1 check("branch_outs", outs(), {26'd0, O_BR});
    drive_ld(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    branch_taken_EX = 1'b1;
    #1 check("branch_prio_outs", outs(), {26'd0, O_BR});
    tick();
    drive_idle();
    #1 check("branch_after_outs", outs(), {26'd0, O_DEF});
    check("branch_state", 32'(fsm_state), 32'(S_RUN));
    check("branch_count", 32'(stall_cycles), 32'd2);

    // Multi-cycle: mc_done four cycles after the start pulse
    exp_q.push_back(O_MC); exp_q.push_back(O_MC); exp_q.push_back(O_MC);
    exp_q.push_back(O_MC); exp_q.push_back(O_DEF);
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      mc_start_EX = (i == 0);
      mc_done = (i == 4);
      branch_taken_EX = (i == 2);
      if (i == 3) drive_ld(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
      #1 check($sformatf("mc_cycle%0d", i), outs(), {26'd0, exp_q.pop_front()});
      tick();
    end
    drive_idle();
    check("mc_state", 32'(fsm_state), 32'(S_RUN));
    check("mc_count", 32'(stall_cycles), 32'd6);

    // Start and done in the same cycle: no stall
    mc_start_EX = 1'b1; mc_done = 1'b1;
    #1 check("mc_same_outs", outs(), {26'd0, O_DEF});
    tick();
    drive_idle();
    check("mc_same_state", 32'(fsm_state), 32'(S_RUN));
    check("mc_same_count", 32'(stall_cycles), 32'd6);

    // Timeout: mc_done never arrives
    mc_start_EX = 1'b1;
    tick();
    drive_idle();
    for (int i = 1; i <= MC_MAX; i++) begin
      #1 check($sformatf("to_wait%0d_state", i), 32'(fsm_state), 32'(S_MCW));
      check($sformatf("to_wait%0d_flag", i), 32'(mc_timeout), 32'd0);
      tick();
    end
    check("to_state", 32'(fsm_state), 32'(S_ERR));
    check("to_flag", 32'(mc_timeout), 32'd1);
    check("to_outs", outs(), {26'd0, O_MC});
    check("to_count", 32'(stall_cycles), 32'd11);
    branch_taken_EX = 1'b1;
    #1 check("err_branch_outs", outs(), {26'd0, O_MC});
    tick();
    drive_idle();
    check("err_branch_state", 32'(fsm_state), 32'(S_ERR));
    check("err_flag_sticky", 32'(mc_timeout), 32'd1);

    // Saturation: stay in ERROR well past 65535 stall cycles
    repeat (65530) tick();
    check("sat_count", 32'(stall_cycles), 32'hFFFF);
    tick();
    check("sat_hold", 32'(stall_cycles), 32'hFFFF);

    // Asynchronous reset mid-ERROR, no clock edge in between
    #1 rst_n = 1'b0;
    #1 check("async_state", 32'(fsm_state), 32'(S_RUN));
    check("async_flag", 32'(mc_timeout), 32'd0);
    check("async_count", 32'(stall_cycles), 32'd0);
    check("async_outs", outs(), {26'd0, O_DEF});
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_state", 32'(fsm_state), 32'(S_RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
